zap_wb_ic: RTL and testbench

ZAP_WB_IC -- requirements
Module: zap_wb_ic

---
 rtl/zap_wb_ic_pkg.sv | 31 +++
 rtl/zap_wb_ic_decode.sv | 20 ++
 rtl/zap_wb_ic.sv | 158 +++++++++++++++
 tb/tb_zap_wb_ic.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_ic_pkg.sv
// zap_wb_ic_pkg: shared constants for the Wishbone interconnect.
// Holds peripheral address windows, slave indices and FSM states.
package zap_wb_ic_pkg;

   localparam logic [31:0] UART_LO  = 32'hFFFF_FFE0;
   localparam logic [31:0] UART_HI  = 32'hFFFF_FFFF;
   localparam logic [31:0] TIMER_LO = 32'hFFFF_FFC0;
   localparam logic [31:0] TIMER_HI = 32'hFFFF_FFDF;
   localparam logic [31:0] VIC_LO   = 32'hFFFF_FFA0;
   localparam logic [31:0] VIC_HI   = 32'hFFFF_FFBF;

   localparam logic [1:0] SLV_RAM   = 2'd0;
   localparam logic [1:0] SLV_UART  = 2'd1;
   localparam logic [1:0] SLV_TIMER = 2'd2;
   localparam logic [1:0] SLV_VIC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   function automatic logic in_rng(
      input logic [31:0] a,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/zap_wb_ic_decode.sv
// zap_wb_ic_decode: combinational address decoder.
// Ports: i_adr (32-bit address) -> o_slv (2-bit slave index).
import zap_wb_ic_pkg::*;

module zap_wb_ic_decode (
   input  logic [31:0] i_adr,
   output logic [1:0]  o_slv
);

   always_comb begin
      o_slv = SLV_RAM;
      unique case (1'b1)
         in_rng(i_adr, UART_LO, UART_HI):   o_slv = SLV_UART;
         in_rng(i_adr, TIMER_LO, TIMER_HI): o_slv = SLV_TIMER;
         in_rng(i_adr, VIC_LO, VIC_HI):     o_slv = SLV_VIC;
         default:                           o_slv = SLV_RAM;
      endcase
   end

endmodule

// File: rtl/zap_wb_ic.sv
// zap_wb_ic: 2-master (CPU=0, DMA=1) to 4-slave Wishbone interconnect
// with round-robin grant and a bus watchdog that raises err on stall.
// Ports: i_clk, i_reset_n (async low); i_m_* master buses (32b lanes);
// o_m_ack/o_m_err per master, o_m_dat shared; o_s_* shared slave bus,
// o_s_cyc/o_s_stb per slave (RAM,UART,TIMER,VIC); i_s_ack, i_s_dat.
import zap_wb_ic_pkg::*;

module zap_wb_ic #(
   parameter int TIMEOUT = 64
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic [1:0]   i_m_cyc,
   input  logic [1:0]   i_m_stb,
   input  logic [1:0]   i_m_we,
   input  logic [63:0]  i_m_adr,
   input  logic [63:0]  i_m_dat,
   input  logic [7:0]   i_m_sel,
   input  logic [5:0]   i_m_cti,
   output logic [1:0]   o_m_ack,
   output logic [1:0]   o_m_err,
   output logic [31:0]  o_m_dat,
   output logic [31:0]  o_s_adr,
   output logic [31:0]  o_s_dat,
   output logic         o_s_we,
   output logic [3:0]   o_s_sel,
   output logic [2:0]   o_s_cti,
   output logic [3:0]   o_s_cyc,
   output logic [3:0]   o_s_stb,
   input  logic [3:0]   i_s_ack,
   input  logic [127:0] i_s_dat
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] WD_LIM = CW'(TIMEOUT - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_last;
   logic            w_last_nxt;
   logic [CW-1:0]   r_wdt;
   logic [CW-1:0]   w_wdt_nxt;

   logic            w_act;
   logic            w_gnt;
   logic            w_cyc;
   logic            w_stb;
   logic            w_we;
   logic [31:0]     w_adr;
   logic [31:0]     w_dat;
   logic [3:0]      w_sel;
   logic [2:0]      w_cti;
   logic [1:0]      w_slv;
   logic            w_sack;
   logic [31:0]     w_sdat;
   logic            w_err;

   assign w_act = (r_state != ST_IDLE);
   assign w_gnt = (r_state == ST_GNT1);

   // Granted master's controls; all zero when nobody owns the bus.
   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      w_cti = '0;
      if (w_act) begin
         w_cyc = i_m_cyc[w_gnt];
         w_stb = i_m_stb[w_gnt];
         w_we  = i_m_we[w_gnt];
         w_adr = w_gnt ? i_m_adr[63:32] : i_m_adr[31:0];
         w_dat = w_gnt ? i_m_dat[63:32] : i_m_dat[31:0];
         w_sel = w_gnt ? i_m_sel[7:4]   : i_m_sel[3:0];
         w_cti = w_gnt ? i_m_cti[5:3]   : i_m_cti[2:0];
      end
   end

   zap_wb_ic_decode u_dec (
      .i_adr (w_adr),
      .o_slv (w_slv)
   );

   assign w_sack = i_s_ack[w_slv];
   assign w_sdat = i_s_dat[{w_slv, 5'd0} +: 32];
   assign w_err  = w_act && w_stb && (r_wdt == WD_LIM);

   assign o_s_adr = w_adr;
   assign o_s_dat = w_dat;
   assign o_s_we  = w_we;
   assign o_s_sel = w_sel;
   assign o_s_cti = w_cti;
   assign o_m_dat = w_act ? w_sdat : '0;

   // Strobe is withheld on the error cycle so the slave sees the abort;
   // a coincident ack is dropped because the error takes precedence.
   always_comb begin
      o_s_cyc = '0;
      o_s_stb = '0;
      o_m_ack = '0;
      o_m_err = '0;
      o_s_cyc[w_slv] = w_cyc;
      o_s_stb[w_slv] = w_stb & ~w_err;
      if (w_act) begin
         o_m_ack[w_gnt] = w_sack & ~w_err;
         o_m_err[w_gnt] = w_err;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      unique case (r_state)
         ST_IDLE: begin
            if (&i_m_cyc)
               w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
            else if (i_m_cyc[0])
               w_state_nxt = ST_GNT0;
            else if (i_m_cyc[1])
               w_state_nxt = ST_GNT1;
         end
         ST_GNT0: begin
            if (!i_m_cyc[0]) begin
               w_last_nxt  = 1'b0;
               w_state_nxt = i_m_cyc[1] ? ST_GNT1 : ST_IDLE;
            end
         end
         ST_GNT1: begin
            if (!i_m_cyc[1]) begin
               w_last_nxt  = 1'b1;
               w_state_nxt = i_m_cyc[0] ? ST_GNT0 : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_wdt_nxt = r_wdt + 1'b1;
      if ((w_state_nxt != r_state) || !w_stb || w_sack || w_err)
         w_wdt_nxt = '0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_wdt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_wdt   <= w_wdt_nxt;
      end
   end

endmodule

// File: tb/tb_zap_wb_ic.sv
// tb_zap_wb_ic: scoreboard bench for zap_wb_ic.
// Directed scenarios plus random traffic against a behavioural model.
module tb_zap_wb_ic;

   localparam int TIMEOUT = 64;

   logic         i_clk = 1'b0;
   logic         i_reset_n;
   logic [1:0]   i_m_cyc, i_m_stb, i_m_we;
   logic [63:0]  i_m_adr, i_m_dat;
   logic [7:0]   i_m_sel;
   logic [5:0]   i_m_cti;
   logic [1:0]   o_m_ack, o_m_err;
   logic [31:0]  o_m_dat, o_s_adr, o_s_dat;
   logic         o_s_we;
   logic [3:0]   o_s_sel;
   logic [2:0]   o_s_cti;
   logic [3:0]   o_s_cyc, o_s_stb;
   logic [3:0]   i_s_ack;
   logic [127:0] i_s_dat;

   zap_wb_ic #(.TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
      .i_m_adr(i_m_adr), .i_m_dat(i_m_dat),
      .i_m_sel(i_m_sel), .i_m_cti(i_m_cti),
      .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_dat(o_m_dat),
      .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_we(o_s_we),
      .o_s_sel(o_s_sel), .o_s_cti(o_s_cti),
      .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
      .i_s_ack(i_s_ack), .i_s_dat(i_s_dat)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [1:0]  m_ack;
      logic [1:0]  m_err;
      logic [31:0] m_dat;
      logic [31:0] s_adr;
      logic [31:0] s_dat;
      logic        s_we;
      logic [3:0]  s_sel;
      logic [2:0]  s_cti;
      logic [3:0]  s_cyc;
      logic [3:0]  s_stb;
   } exp_t;

   exp_t q[$];

   // Reference model: who owns the bus (-1 none), who went last,
   // and how many consecutive cycles the owner has been left waiting.
   int owner, last, stall;
   int n_vec = 0;
   int n_bad = 0;
   int timer_we_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic int dec(input logic [31:0] a);
      if (a >= 32'hFFFF_FFE0) return 1;
      if (a >= 32'hFFFF_FFC0) return 2;
      if (a >= 32'hFFFF_FFA0) return 3;
      return 0;
   endfunction

   task automatic expect_now();
      exp_t e;
      int   g, k;
      bit   stb, err;
      e = '0;
      if (owner >= 0) begin
         g   = owner;
         k   = dec(i_m_adr[g*32 +: 32]);
         stb = i_m_stb[g];
         err = stb && (stall == TIMEOUT - 1);
         e.s_adr    = i_m_adr[g*32 +: 32];
         e.s_dat    = i_m_dat[g*32 +: 32];
         e.s_we     = i_m_we[g];
         e.s_sel    = i_m_sel[g*4 +: 4];
         e.s_cti    = i_m_cti[g*3 +: 3];
         e.s_cyc[k] = i_m_cyc[g];
         e.s_stb[k] = stb && !err;
         e.m_ack[g] = i_s_ack[k] && !err;
         e.m_err[g] = err;
         e.m_dat    = i_s_dat[k*32 +: 32];
      end
      q.push_back(e);
   endtask

   task automatic model_update();
      int nxt, k;
      bit stb, ack, err;
      stb = 0; ack = 0; err = 0;
      if (owner >= 0) begin
         k   = dec(i_m_adr[owner*32 +: 32]);
         stb = i_m_stb[owner];
         ack = i_s_ack[k];
         err = stb && (stall == TIMEOUT - 1);
      end
      if (owner < 0) begin
         if (i_m_cyc == 2'b11) nxt = 1 - last;
         else if (i_m_cyc[0])  nxt = 0;
         else if (i_m_cyc[1])  nxt = 1;
         else                  nxt = -1;
      end else if (i_m_cyc[owner]) begin
         nxt = owner;
      end else begin
         last = owner;
         nxt  = i_m_cyc[1-owner] ? 1 - owner : -1;
      end
      if (nxt == owner && stb && !ack && !err) stall++;
      else stall = 0;
      owner = nxt;
   endtask

   task automatic step();
      expect_now();
      @(posedge i_clk);
      model_update();
      #1;
   endtask

   task automatic set_m(input int n, input bit cyc, input bit stb,
                        input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [2:0] cti);
      i_m_cyc[n] = cyc;
      i_m_stb[n] = stb;
      i_m_we[n]  = we;
      i_m_adr[n*32 +: 32] = adr;
      i_m_dat[n*32 +: 32] = dat;
      i_m_sel[n*4 +: 4]   = 4'hF;
      i_m_cti[n*3 +: 3]   = cti;
   endtask

   task automatic do_reset(input bit clr, input logic [3:0] ack_in);
      @(negedge i_clk);
      #1;
      if (clr) begin
         i_m_cyc = '0; i_m_stb = '0; i_m_we = '0;
         i_m_adr = '0; i_m_dat = '0; i_m_sel = '0; i_m_cti = '0;
         i_s_dat = '0;
      end
      i_s_ack   = ack_in;
      i_reset_n = 1'b0;
      #1;
      chk("rst_m_ack", o_m_ack, 0);
      chk("rst_m_err", o_m_err, 0);
      chk("rst_m_dat", o_m_dat, 0);
      chk("rst_s_adr", o_s_adr, 0);
      chk("rst_s_dat", o_s_dat, 0);
      chk("rst_s_we",  o_s_we,  0);
      chk("rst_s_sel", o_s_sel, 0);
      chk("rst_s_cti", o_s_cti, 0);
      chk("rst_s_cyc", o_s_cyc, 0);
      chk("rst_s_stb", o_s_stb, 0);
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      owner = -1;
      last  = 1;
      stall = 0;
   endtask

   function automatic logic [31:0] rand_adr();
      case ($urandom_range(0, 9))
         0: return $urandom;
         1: return 32'hFFFF_FF9F;
         2: return 32'hFFFF_FFA0;
         3: return 32'hFFFF_FFBF;
         4: return 32'hFFFF_FFC0;
         5: return 32'hFFFF_FFDF;
         6: return 32'hFFFF_FFE0;
         7: return 32'hFFFF_FFFF;
         8: return 32'hFFFF_FFA0 + 32'($urandom_range(0, 95));
         default: return 32'($urandom_range(0, 4095));
      endcase
   endfunction

   // Monitor: compares every presented cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (o_s_cyc[2] && o_s_stb[2] && o_s_we) timer_we_cnt++;
         if (|o_m_err) err_cnt++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("m_ack", o_m_ack, e.m_ack);
            chk("m_err", o_m_err, e.m_err);
            chk("m_dat", o_m_dat, e.m_dat);
            chk("s_adr", o_s_adr, e.s_adr);
            chk("s_dat", o_s_dat, e.s_dat);
            chk("s_we",  o_s_we,  e.s_we);
            chk("s_sel", o_s_sel, e.s_sel);
            chk("s_cti", o_s_cti, e.s_cti);
            chk("s_cyc", o_s_cyc, e.s_cyc);
            chk("s_stb", o_s_stb, e.s_stb);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int snap;
      owner = -1; last = 1; stall = 0;
      i_reset_n = 1'b0;
      i_m_cyc = '0; i_m_stb = '0; i_m_we = '0;
      i_m_adr = '0; i_m_dat = '0; i_m_sel = '0; i_m_cti = '0;
      i_s_ack = '0; i_s_dat = '0;

      // CPU read of 0x100, RAM acks after two wait cycles
      do_reset(1, 4'b0000);
      set_m(0, 1, 1, 0, 32'h0000_0100, 32'h0, 3'b000);
      step();
      step();
      step();
      i_s_ack = 4'b0001;
      i_s_dat[31:0] = 32'hCAFE_0100;
      step();
      i_s_ack = 4'b0000;
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      step();
      step();

      // Simultaneous requests: CPU, then DMA on handover, then CPU
      do_reset(1, 4'b0000);
      i_s_ack = 4'b0001;
      set_m(0, 1, 1, 0, 32'h0000_0200, 32'h11, 3'b000);
      set_m(1, 1, 1, 0, 32'h0000_0300, 32'h22, 3'b000);
      step();
      chk("arb_first", o_s_adr, 32'h0000_0200);
      step();
      set_m(0, 0, 0, 0, 32'h0000_0200, 32'h11, 3'b000);
      step();
      chk("arb_handover", o_s_adr, 32'h0000_0300);
      step();
      set_m(1, 0, 0, 0, 32'h0000_0300, 32'h22, 3'b000);
      step();
      set_m(0, 1, 1, 0, 32'h0000_0200, 32'h11, 3'b000);
      set_m(1, 1, 1, 0, 32'h0000_0300, 32'h22, 3'b000);
      step();
      chk("arb_second", o_s_adr, 32'h0000_0200);
      step();
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      step();
      step();
      step();

      // DMA timer write held off by a 4-beat CPU burst
      do_reset(1, 4'b0000);
      snap = timer_we_cnt;
      i_s_ack = 4'b0101;
      set_m(0, 1, 1, 0, 32'h0000_0400, 32'h0, 3'b010);
      set_m(1, 1, 1, 1, 32'hFFFF_FFC4, 32'h5A5A_0001, 3'b000);
      step();
      for (int i = 0; i < 4; i++) begin
         set_m(0, 1, 1, 0, 32'h0000_0400 + 32'(4*i), 32'h0,
               (i == 3) ? 3'b111 : 3'b010);
         step();
      end
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      step();
      step();
      set_m(1, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      step();
      step();
      chk("timer_we_cycles", timer_we_cnt - snap, 1);

      // VIC never acks: error on the 64th strobe cycle
      do_reset(1, 4'b0000);
      snap = err_cnt;
      set_m(0, 1, 1, 0, 32'hFFFF_FFA8, 32'h0, 3'b000);
      step();
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      chk("wd_early", err_cnt - snap, 0);
      step();
      chk("wd_fire", err_cnt - snap, 1);
      for (int i = 0; i < 6; i++) step();
      chk("wd_once", err_cnt - snap, 1);
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      step();
      step();

      // Reset in the middle of a UART access
      do_reset(1, 4'b0000);
      set_m(0, 1, 1, 1, 32'hFFFF_FFE4, 32'h0000_00AA, 3'b000);
      step();
      step();
      step();
      do_reset(0, 4'b0010);
      i_s_ack = 4'b0000;
      step();
      step();
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      step();
      step();
      set_m(0, 1, 1, 0, 32'hFFFF_FFE8, 32'h0, 3'b000);
      i_s_ack = 4'b0010;
      step();
      step();
      set_m(0, 0, 0, 0, 32'h0, 32'h0, 3'b000);
      i_s_ack = 4'b0000;
      step();

      // Random traffic
      do_reset(1, 4'b0000);
      for (int b = 0; b < 20; b++) begin
         int ackp;
         ackp = $urandom_range(0, 4);
         for (int c = 0; c < 200; c++) begin
            for (int n = 0; n < 2; n++) begin
               if ($urandom_range(0, 29) == 0) i_m_cyc[n] = ~i_m_cyc[n];
               if ($urandom_range(0, 7) == 0) i_m_adr[n*32 +: 32] = rand_adr();
               i_m_stb[n] = i_m_cyc[n] &&
                            ((b % 2 == 0) || ($urandom_range(0, 5) != 0));
               i_m_we[n]  = 1'($urandom);
               i_m_dat[n*32 +: 32] = $urandom;
               i_m_sel[n*4 +: 4]   = 4'($urandom);
               i_m_cti[n*3 +: 3]   = 3'($urandom);
            end
            for (int k = 0; k < 4; k++)
               i_s_ack[k] = (ackp != 0) && ($urandom_range(0, ackp) == 0);
            i_s_dat = {$urandom, $urandom, $urandom, $urandom};
            step();
         end
      end

      @(negedge i_clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
